// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared memory, counts retired instructions and latches illegal-op traps.
module mc_ctrl #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          Op,
  input  logic [6:0]          Funct7,
  input  logic [2:0]          Funct3,
  input  logic                Zero,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                IRWrite,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                RegWrite,
  output logic                ALUSrc,
  output logic [5:0]          EXTOp,
  output logic [4:0]          ALUOp,
  output logic [4:0]          NPCOp,
  output logic [1:0]          WDSel,
  output logic                trap,
  output logic [RETIRE_W-1:0] retired
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [5:0] EXT_NONE = 6'b000000;
  localparam logic [5:0] EXT_I    = 6'b010000;
  localparam logic [5:0] EXT_S    = 6'b001000;
  localparam logic [5:0] EXT_B    = 6'b000100;
  localparam logic [5:0] EXT_U    = 6'b000010;

  localparam logic [4:0] ALU_NOP = 5'b00000;
  localparam logic [4:0] ALU_LUI = 5'b00001;
  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_SUB = 5'b00100;
  localparam logic [4:0] ALU_XOR = 5'b01100;
  localparam logic [4:0] ALU_OR  = 5'b01101;
  localparam logic [4:0] ALU_AND = 5'b01110;
  localparam logic [4:0] ALU_SLL = 5'b01111;
  localparam logic [4:0] ALU_SRL = 5'b10000;
  localparam logic [4:0] ALU_SRA = 5'b10001;

  localparam logic [4:0] NPC_PLUS4  = 5'b00000;
  localparam logic [4:0] NPC_BRANCH = 5'b00001;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;

  localparam logic [RETIRE_W-1:0] RETIRE_ONE = RETIRE_W'(1'b1);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC   = 4'd2,
    ALUWB  = 4'd3,
    MEMADR = 4'd4,
    MEMRD  = 4'd5,
    MEMWB  = 4'd6,
    MEMWR  = 4'd7,
    BRANCH = 4'd8,
    TRAP   = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    C_R    = 3'd0,
    C_ADDI = 3'd1,
    C_LW   = 3'd2,
    C_SW   = 3'd3,
    C_LUI  = 3'd4,
    C_BEQ  = 3'd5,
    C_ILL  = 3'd6
  } cls_t;

  state_t                state_q, state_d;
  logic                  trap_q, trap_d;
  logic [RETIRE_W-1:0]   retired_q, retired_d;

  cls_t                  cls;
  logic                  r_legal;
  logic [4:0]            r_aluop;
  logic                  retire_inc;

  logic                  pc_write_s, ir_write_s, iord_s, mem_read_s, mem_write_s;
  logic                  reg_write_s, alu_src_s;
  logic [5:0]            ext_op_s;
  logic [4:0]            alu_op_s, npc_op_s;
  logic [1:0]            wd_sel_s;

  // Returns {legal, aluop} for an R-type funct7/funct3 pair.
  function automatic logic [5:0] r_decode(input logic [6:0] f7, input logic [2:0] f3);
    case ({f7, f3})
      10'b0000000_000: r_decode = {1'b1, ALU_ADD};
      10'b0100000_000: r_decode = {1'b1, ALU_SUB};
      10'b0000000_001: r_decode = {1'b1, ALU_SLL};
      10'b0000000_100: r_decode = {1'b1, ALU_XOR};
      10'b0000000_101: r_decode = {1'b1, ALU_SRL};
      10'b0100000_101: r_decode = {1'b1, ALU_SRA};
      10'b0000000_110: r_decode = {1'b1, ALU_OR};
      10'b0000000_111: r_decode = {1'b1, ALU_AND};
      default:         r_decode = {1'b0, ALU_NOP};
    endcase
  endfunction

  // Classify the instruction held in IR.
  always_comb begin
    {r_legal, r_aluop} = r_decode(Funct7, Funct3);
    cls = C_ILL;
    case (Op)
      OP_R:    if (r_legal) cls = C_R; else cls = C_ILL;
      OP_I:    if (Funct3 == 3'b000) cls = C_ADDI; else cls = C_ILL;
      OP_LW:   if (Funct3 == 3'b010) cls = C_LW; else cls = C_ILL;
      OP_SW:   if (Funct3 == 3'b010) cls = C_SW; else cls = C_ILL;
      OP_LUI:  cls = C_LUI;
      OP_BEQ:  if (Funct3 == 3'b000) cls = C_BEQ; else cls = C_ILL;
      default: cls = C_ILL;
    endcase
  end

  // Moore control decode; only FETCH (mem_ready) and BRANCH (Zero) look at inputs.
  always_comb begin
    pc_write_s  = 1'b0;
    ir_write_s  = 1'b0;
    iord_s      = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    alu_src_s   = 1'b0;
    ext_op_s    = EXT_NONE;
    alu_op_s    = ALU_NOP;
    npc_op_s    = NPC_PLUS4;
    wd_sel_s    = WD_ALU;
    case (state_q)
      FETCH: begin
        iord_s     = 1'b0;
        mem_read_s = 1'b1;
        if (mem_ready) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          npc_op_s   = NPC_PLUS4;
        end else begin
          ir_write_s = 1'b0;
          pc_write_s = 1'b0;
        end
      end
      EXEC, ALUWB: begin
        case (cls)
          C_R: begin
            alu_src_s = 1'b0;
            alu_op_s  = r_aluop;
          end
          C_ADDI: begin
            alu_src_s = 1'b1;
            ext_op_s  = EXT_I;
            alu_op_s  = ALU_ADD;
          end
          C_LUI: begin
            alu_src_s = 1'b1;
            ext_op_s  = EXT_U;
            alu_op_s  = ALU_LUI;
          end
          default: alu_op_s = ALU_NOP;
        endcase
        if (state_q == ALUWB) begin
          reg_write_s = 1'b1;
          wd_sel_s    = WD_ALU;
        end else begin
          reg_write_s = 1'b0;
        end
      end
      // Address generation controls stay up through the memory access.
      MEMADR, MEMRD, MEMWR: begin
        alu_src_s = 1'b1;
        alu_op_s  = ALU_ADD;
        if (cls == C_SW) ext_op_s = EXT_S; else ext_op_s = EXT_I;
        if (state_q == MEMRD) begin
          iord_s     = 1'b1;
          mem_read_s = 1'b1;
        end else if (state_q == MEMWR) begin
          iord_s      = 1'b1;
          mem_write_s = 1'b1;
        end else begin
          iord_s = 1'b0;
        end
      end
      MEMWB: begin
        reg_write_s = 1'b1;
        wd_sel_s    = WD_MEM;
      end
      BRANCH: begin
        alu_src_s = 1'b0;
        alu_op_s  = ALU_SUB;
        ext_op_s  = EXT_B;
        if (Zero) begin
          pc_write_s = 1'b1;
          npc_op_s   = NPC_BRANCH;
        end else begin
          pc_write_s = 1'b0;
        end
      end
      default: pc_write_s = 1'b0;
    endcase
  end

  // Outputs are held at zero while reset is asserted.
  always_comb begin
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      ALUSrc   = 1'b0;
      EXTOp    = EXT_NONE;
      ALUOp    = ALU_NOP;
      NPCOp    = NPC_PLUS4;
      WDSel    = WD_ALU;
      trap     = 1'b0;
      retired  = '0;
    end else begin
      PCWrite  = pc_write_s;
      IRWrite  = ir_write_s;
      IorD     = iord_s;
      MemRead  = mem_read_s;
      MemWrite = mem_write_s;
      RegWrite = reg_write_s;
      ALUSrc   = alu_src_s;
      EXTOp    = ext_op_s;
      ALUOp    = alu_op_s;
      NPCOp    = npc_op_s;
      WDSel    = wd_sel_s;
      trap     = trap_q;
      retired  = retired_q;
    end
  end

  // Next state, trap latch and retire strobe.
  always_comb begin
    state_d    = state_q;
    trap_d     = trap_q;
    retire_inc = 1'b0;
    case (state_q)
      FETCH:  if (mem_ready) state_d = DECODE; else state_d = FETCH;
      DECODE: begin
        case (cls)
          C_R, C_ADDI, C_LUI: state_d = EXEC;
          C_LW, C_SW:         state_d = MEMADR;
          C_BEQ:              state_d = BRANCH;
          default: begin
            state_d = TRAP;
            trap_d  = 1'b1;
          end
        endcase
      end
      EXEC:   state_d = ALUWB;
      ALUWB: begin
        state_d    = FETCH;
        retire_inc = 1'b1;
      end
      MEMADR: if (cls == C_SW) state_d = MEMWR; else state_d = MEMRD;
      MEMRD:  if (mem_ready) state_d = MEMWB; else state_d = MEMRD;
      MEMWB: begin
        state_d    = FETCH;
        retire_inc = 1'b1;
      end
      MEMWR: begin
        if (mem_ready) begin
          state_d    = FETCH;
          retire_inc = 1'b1;
        end else begin
          state_d = MEMWR;
        end
      end
      BRANCH: begin
        state_d    = FETCH;
        retire_inc = 1'b1;
      end
      TRAP: begin
        state_d = TRAP;
        trap_d  = 1'b1;
      end
      default: state_d = FETCH;
    endcase
    if (retire_inc) retired_d = retired_q + RETIRE_ONE; else retired_d = retired_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      trap_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      trap_q    <= trap_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle control vectors for each instruction class,
// memory waits, traps, reset mid-instruction and retired-counter wrap (RETIRE_W=4 copy).
module tb_mc_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, Zero, mem_ready;
  logic [6:0] Op, Funct7;
  logic [2:0] Funct3;

  logic        PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, ALUSrc, trap;
  logic [5:0]  EXTOp;
  logic [4:0]  ALUOp, NPCOp;
  logic [1:0]  WDSel;
  logic [31:0] retired;

  logic        pcw4, irw4, iord4, mr4, mw4, rw4, asrc4, trap4;
  logic [5:0]  ext4;
  logic [4:0]  aop4, npc4;
  logic [1:0]  wd4;
  logic [3:0]  retired4;

  mc_ctrl #(.RETIRE_W(32)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct7(Funct7), .Funct3(Funct3), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
    .EXTOp(EXTOp), .ALUOp(ALUOp), .NPCOp(NPCOp), .WDSel(WDSel), .trap(trap),
    .retired(retired)
  );

  mc_ctrl #(.RETIRE_W(4)) dut4 (
    .clk(clk), .rst(rst), .Op(Op), .Funct7(Funct7), .Funct3(Funct3), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(pcw4), .IRWrite(irw4), .IorD(iord4),
    .MemRead(mr4), .MemWrite(mw4), .RegWrite(rw4), .ALUSrc(asrc4),
    .EXTOp(ext4), .ALUOp(aop4), .NPCOp(npc4), .WDSel(wd4), .trap(trap4),
    .retired(retired4)
  );

  logic [25:0] ctl_s, ctl4_s;
  assign ctl_s  = {PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, ALUSrc,
                   EXTOp, ALUOp, NPCOp, WDSel, trap};
  assign ctl4_s = {pcw4, irw4, iord4, mr4, mw4, rw4, asrc4, ext4, aop4, npc4, wd4, trap4};

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [5:0] EX_I = 6'b010000, EX_S = 6'b001000, EX_B = 6'b000100, EX_U = 6'b000010;
  localparam logic [4:0] A_ADD = 5'b00011, A_SUB = 5'b00100, A_LUI = 5'b00001;

  int checks = 0;
  int failures = 0;
  int exp_ret = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] ctl(input logic pcw, input logic irw, input logic iord,
                                      input logic mr, input logic mw, input logic rw,
                                      input logic asrc, input logic [5:0] ext,
                                      input logic [4:0] aop, input logic [4:0] npc,
                                      input logic [1:0] wd, input logic tr);
    return {pcw, irw, iord, mr, mw, rw, asrc, ext, aop, npc, wd, tr};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_ctl(input string tag, input logic [25:0] e);
    #1;
    check_eq(tag, {6'd0, ctl_s}, {6'd0, e});
    check_eq({tag, "_w4"}, {6'd0, ctl4_s}, {6'd0, e});
  endtask

  task automatic check_ret(input string tag, input int n);
    check_eq(tag, retired, n);
    check_eq({tag, "_w4"}, {28'd0, retired4}, {28'd0, n[3:0]});
  endtask

  task automatic set_ins(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3);
    Op = op;
    Funct7 = f7;
    Funct3 = f3;
  endtask

  // Four-cycle ALU instruction with mem_ready high; checks EXEC/ALUWB controls.
  task automatic alu_ins(input string tag, input logic asrc, input logic [5:0] ext,
                         input logic [4:0] aop);
    mem_ready = 1'b1;
    exp_ctl({tag, "_fetch"}, ctl(1, 1, 0, 1, 0, 0, 0, 6'd0, 5'd0, 5'd0, 2'd0, 0));
    tick();
    exp_ctl({tag, "_dec"}, 26'd0);
    tick();
    exp_ctl({tag, "_exec"}, ctl(0, 0, 0, 0, 0, 0, asrc, ext, aop, 5'd0, 2'd0, 0));
    tick();
    exp_ctl({tag, "_wb"}, ctl(0, 0, 0, 0, 0, 1, asrc, ext, aop, 5'd0, 2'd0, 0));
    tick();
    exp_ret++;
    check_ret({tag, "_ret"}, exp_ret);
  endtask

  logic [6:0] rf7 [7] = '{7'b0100000, 7'b0000000, 7'b0000000, 7'b0000000,
                          7'b0100000, 7'b0000000, 7'b0000000};
  logic [2:0] rf3 [7] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b101, 3'b110, 3'b111};
  logic [4:0] rop [7] = '{5'b00100, 5'b01111, 5'b01100, 5'b10000, 5'b10001,
                          5'b01101, 5'b01110};

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; Zero = 1'b0; mem_ready = 1'b0;
    set_ins(7'd0, 7'd0, 3'd0);
    tick();
    exp_ctl("rst_ctl", 26'd0);
    check_ret("rst_ret", 0);
    rst = 1'b0;

    // R-type add
    set_ins(OP_R, 7'd0, 3'b000);
    alu_ins("add", 1'b0, 6'd0, A_ADD);

    // lw with two wait cycles in MEMRD
    set_ins(OP_LW, 7'd0, 3'b010);
    exp_ctl("lw_fetch", ctl(1, 1, 0, 1, 0, 0, 0, 6'd0, 5'd0, 5'd0, 2'd0, 0));
    tick();
    exp_ctl("lw_dec", 26'd0);
    tick();
    mem_ready = 1'b0;
    exp_ctl("lw_madr", ctl(0, 0, 0, 0, 0, 0, 1, EX_I, A_ADD, 5'd0, 2'd0, 0));
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_ready = 1'b1;
      exp_ctl("lw_mrd", ctl(0, 0, 1, 1, 0, 0, 1, EX_I, A_ADD, 5'd0, 2'd0, 0));
      tick();
    end
    exp_ctl("lw_mwb", ctl(0, 0, 0, 0, 0, 1, 0, 6'd0, 5'd0, 5'd0, 2'b01, 0));
    tick();
    exp_ret++;
    check_ret("lw_ret", exp_ret);

    // sw with one wait cycle in MEMWR
    set_ins(OP_SW, 7'd0, 3'b010);
    exp_ctl("sw_fetch", ctl(1, 1, 0, 1, 0, 0, 0, 6'd0, 5'd0, 5'd0, 2'd0, 0));
    tick();
    exp_ctl("sw_dec", 26'd0);
    tick();
    mem_ready = 1'b0;
    exp_ctl("sw_madr", ctl(0, 0, 0, 0, 0, 0, 1, EX_S, A_ADD, 5'd0, 2'd0, 0));
    tick();
    exp_ctl("sw_wait", ctl(0, 0, 1, 0, 1, 0, 1, EX_S, A_ADD, 5'd0, 2'd0, 0));
    check_ret("sw_ret_wait", exp_ret);
    tick();
    mem_ready = 1'b1;
    exp_ctl("sw_mwr", ctl(0, 0, 1, 0, 1, 0, 1, EX_S, A_ADD, 5'd0, 2'd0, 0));
    tick();
    exp_ret++;
    check_ret("sw_ret", exp_ret);

    // beq taken, with one fetch wait
    set_ins(OP_BEQ, 7'd0, 3'b000);
    mem_ready = 1'b0;
    exp_ctl("beq_fwait", ctl(0, 0, 0, 1, 0, 0, 0, 6'd0, 5'd0, 5'd0, 2'd0, 0));
    tick();
    mem_ready = 1'b1;
    exp_ctl("beq_fetch", ctl(1, 1, 0, 1, 0, 0, 0, 6'd0, 5'd0, 5'd0, 2'd0, 0));
    tick();
    exp_ctl("beq_dec", 26'd0);
    tick();
    Zero = 1'b0;
    exp_ctl("beq_z0", ctl(0, 0, 0, 0, 0, 0, 0, EX_B, A_SUB, 5'd0, 2'd0, 0));
    Zero = 1'b1;
    exp_ctl("beq_taken", ctl(1, 0, 0, 0, 0, 0, 0, EX_B, A_SUB, 5'b00001, 2'd0, 0));
    tick();
    Zero = 1'b0;
    exp_ret++;
    check_ret("beq_t_ret", exp_ret);

    // beq not taken
    exp_ctl("beqn_fetch", ctl(1, 1, 0, 1, 0, 0, 0, 6'd0, 5'd0, 5'd0, 2'd0, 0));
    tick();
    exp_ctl("beqn_dec", 26'd0);
    tick();
    exp_ctl("beqn_br", ctl(0, 0, 0, 0, 0, 0, 0, EX_B, A_SUB, 5'd0, 2'd0, 0));
    tick();
    exp_ret++;
    check_ret("beq_n_ret", exp_ret);

    // remaining R-type functs, then lui
    for (int i = 0; i < 7; i++) begin
      set_ins(OP_R, rf7[i], rf3[i]);
      alu_ins($sformatf("rtype%0d", i), 1'b0, 6'd0, rop[i]);
    end
    set_ins(OP_LUI, 7'd0, 3'd0);
    alu_ins("lui", 1'b1, EX_U, A_LUI);

    // illegal opcode: trap held for 20 cycles regardless of inputs
    set_ins(7'b1111111, 7'd0, 3'd0);
    exp_ctl("ill_fetch", ctl(1, 1, 0, 1, 0, 0, 0, 6'd0, 5'd0, 5'd0, 2'd0, 0));
    tick();
    exp_ctl("ill_dec", 26'd0);
    tick();
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      Zero = i[1];
      exp_ctl("ill_trap", ctl(0, 0, 0, 0, 0, 0, 0, 6'd0, 5'd0, 5'd0, 2'd0, 1));
      tick();
    end
    check_ret("ill_ret", exp_ret);
    rst = 1'b1;
    mem_ready = 1'b1;
    exp_ctl("ill_rst", 26'd0);
    check_ret("ill_rst_ret", 0);
    tick();
    rst = 1'b0;
    exp_ret = 0;
    exp_ctl("ill_after", ctl(1, 1, 0, 1, 0, 0, 0, 6'd0, 5'd0, 5'd0, 2'd0, 0));
    check_ret("ill_after_ret", exp_ret);

    // R-type with funct7=0000001 traps too
    set_ins(OP_R, 7'b0000001, 3'b000);
    tick();
    exp_ctl("mul_dec", 26'd0);
    tick();
    exp_ctl("mul_trap", ctl(0, 0, 0, 0, 0, 0, 0, 6'd0, 5'd0, 5'd0, 2'd0, 1));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_ctl("mul_after", ctl(1, 1, 0, 1, 0, 0, 0, 6'd0, 5'd0, 5'd0, 2'd0, 0));

    // reset during a MEMRD wait abandons the load
    set_ins(OP_I, 7'd0, 3'b000);
    alu_ins("pre_addi", 1'b1, EX_I, A_ADD);
    set_ins(OP_LW, 7'd0, 3'b010);
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    exp_ctl("rmr_mrd", ctl(0, 0, 1, 1, 0, 0, 1, EX_I, A_ADD, 5'd0, 2'd0, 0));
    tick();
    rst = 1'b1;
    exp_ctl("rmr_rst", 26'd0);
    check_ret("rmr_rst_ret", 0);
    tick();
    rst = 1'b0;
    exp_ret = 0;
    exp_ctl("rmr_fwait", ctl(0, 0, 0, 1, 0, 0, 0, 6'd0, 5'd0, 5'd0, 2'd0, 0));
    check_ret("rmr_ret0", exp_ret);
    tick();
    mem_ready = 1'b1;
    tick();
    exp_ctl("rmr_dec_pulse", 26'd0);
    tick();
    mem_ready = 1'b0;
    exp_ctl("rmr_madr", ctl(0, 0, 0, 0, 0, 0, 1, EX_I, A_ADD, 5'd0, 2'd0, 0));
    tick();
    mem_ready = 1'b1;
    exp_ctl("rmr_mrd2", ctl(0, 0, 1, 1, 0, 0, 1, EX_I, A_ADD, 5'd0, 2'd0, 0));
    tick();
    exp_ctl("rmr_mwb", ctl(0, 0, 0, 0, 0, 1, 0, 6'd0, 5'd0, 5'd0, 2'b01, 0));
    tick();
    exp_ret++;
    check_ret("rmr_ret1", exp_ret);

    // 17 addi: 4-bit counter wraps 15 -> 0 -> 1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_ret = 0;
    set_ins(OP_I, 7'd0, 3'b000);
    for (int k = 0; k < 17; k++) begin
      alu_ins("wrap", 1'b1, EX_I, A_ADD);
    end
    check_eq("wrap_w4_final", {28'd0, retired4}, 32'd1);
    check_eq("wrap_final", retired, 32'd17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
